// File: rtl/hangman_pkg.sv
// Shared definitions for the host and player hangman controllers.
package hangman_pkg;

    localparam int WORD_LEN     = 5;
    localparam int MAX_MISTAKES = 6;

    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_Z  = 8'h5A;
    localparam logic [7:0] ASCII_US = 8'h5F;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT,
        CHECK,
        APPLY,
        WIN,
        LOSE
    } state_t;

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_A) && (c <= ASCII_Z);
    endfunction

    function automatic logic word_ok(input logic [39:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < WORD_LEN; i++) begin
            ok = ok & is_upper(w[i*8 +: 8]);
        end
        return ok;
    endfunction

endpackage

// File: rtl/letter_match.sv
// Compares one guess byte against every letter of the word; bit4 of mask is the leftmost letter.
module letter_match
    import hangman_pkg::*;
(
    input  logic [39:0] word,
    input  logic [7:0]  guess,
    output logic [4:0]  mask,
    output logic [2:0]  count
);

    always_comb begin
        mask  = '0;
        count = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (word[i*8 +: 8] == guess) begin
                mask[i] = 1'b1;
                count   = count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/host_game_ctrl.sv
// Host-side hangman sequencer: latches the word, checks guesses, and issues one-cycle display commands.
module host_game_ctrl
    import hangman_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic        word_valid,
    input  logic [39:0] word_in,
    input  logic        guess_valid,
    input  logic [7:0]  guess_in,
    output logic        guess_ready,
    input  logic        restart,
    output logic [7:0]  letter,
    output logic [4:0]  indexCorrect,
    output logic        mistake,
    output logic [2:0]  numMistake,
    output logic [2:0]  correct,
    output logic [39:0] word,
    output logic        gameEnd_host,
    output logic        game_over,
    output logic        win
);

    state_t      state_q, state_d;
    logic [25:0] used_q, used_d;
    logic [7:0]  guess_q, guess_d;
    logic [39:0] word_d;
    logic [7:0]  letter_d;
    logic [4:0]  idx_d;
    logic        mistake_d, ready_d, ge_d, over_d, win_d;
    logic [2:0]  num_d, cor_d;

    logic [4:0]  match_mask;
    logic [2:0]  match_cnt;
    logic [4:0]  used_idx;
    logic [3:0]  cor_sum;

    letter_match u_match (
        .word  (word),
        .guess (guess_q),
        .mask  (match_mask),
        .count (match_cnt)
    );

    // 'A'..'Z' have low five bits 1..26, so subtracting one gives the used-mask index.
    assign used_idx = guess_q[4:0] - 5'd1;
    assign cor_sum  = {1'b0, correct} + {1'b0, match_cnt};

    always_comb begin
        state_d   = state_q;
        used_d    = used_q;
        guess_d   = guess_q;
        word_d    = word;
        letter_d  = letter;
        idx_d     = '0;
        mistake_d = 1'b0;
        num_d     = numMistake;
        cor_d     = correct;
        ge_d      = 1'b0;
        ready_d   = 1'b0;
        over_d    = 1'b0;
        win_d     = 1'b0;

        if (restart && state_q != IDLE) begin
            state_d = IDLE;
            ge_d    = 1'b1;
            used_d  = '0;
            num_d   = '0;
            cor_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (word_valid && word_ok(word_in)) begin
                        word_d  = word_in;
                        used_d  = '0;
                        num_d   = '0;
                        cor_d   = '0;
                        ge_d    = 1'b1;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    ready_d = 1'b1;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (guess_valid && guess_ready) begin
                        guess_d = guess_in;
                        state_d = CHECK;
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (!is_upper(guess_q) || used_q[used_idx]) begin
                        ready_d = 1'b1;
                        state_d = WAIT;
                    end else begin
                        used_d[used_idx] = 1'b1;
                        letter_d         = guess_q;
                        state_d          = APPLY;
                        if (match_mask != '0) begin
                            idx_d = match_mask;
                            cor_d = (cor_sum > 4'(WORD_LEN)) ? 3'(WORD_LEN) : cor_sum[2:0];
                        end else begin
                            mistake_d = 1'b1;
                            num_d     = numMistake + 3'd1;
                        end
                    end
                end
                APPLY: begin
                    if (correct == 3'(WORD_LEN)) begin
                        over_d  = 1'b1;
                        win_d   = 1'b1;
                        state_d = WIN;
                    end else if (numMistake == 3'(MAX_MISTAKES)) begin
                        over_d    = 1'b1;
                        mistake_d = 1'b1;
                        state_d   = LOSE;
                    end else begin
                        ready_d = 1'b1;
                        state_d = WAIT;
                    end
                end
                WIN: begin
                    over_d = 1'b1;
                    win_d  = 1'b1;
                end
                LOSE: begin
                    over_d    = 1'b1;
                    mistake_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are registered alongside the state so each command lines up with its state cycle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            used_q       <= '0;
            guess_q      <= '0;
            word         <= {5{ASCII_US}};
            letter       <= '0;
            indexCorrect <= '0;
            mistake      <= 1'b0;
            numMistake   <= '0;
            correct      <= '0;
            gameEnd_host <= 1'b0;
            guess_ready  <= 1'b0;
            game_over    <= 1'b0;
            win          <= 1'b0;
        end else begin
            state_q      <= state_d;
            used_q       <= used_d;
            guess_q      <= guess_d;
            word         <= word_d;
            letter       <= letter_d;
            indexCorrect <= idx_d;
            mistake      <= mistake_d;
            numMistake   <= num_d;
            correct      <= cor_d;
            gameEnd_host <= ge_d;
            guess_ready  <= ready_d;
            game_over    <= over_d;
            win          <= win_d;
        end
    end

endmodule

// File: tb/tb_host_game_ctrl.sv
// Self-checking bench for host_game_ctrl: directed tables, corner sequences and randomized games.
module tb_host_game_ctrl;

    logic        clk = 1'b0;
    logic        nRst;
    logic        word_valid;
    logic [39:0] word_in;
    logic        guess_valid;
    logic [7:0]  guess_in;
    logic        guess_ready;
    logic        restart;
    logic [7:0]  letter;
    logic [4:0]  indexCorrect;
    logic        mistake;
    logic [2:0]  numMistake;
    logic [2:0]  correct;
    logic [39:0] word;
    logic        gameEnd_host;
    logic        game_over;
    logic        win;

    host_game_ctrl dut (
        .clk          (clk),
        .nRst         (nRst),
        .word_valid   (word_valid),
        .word_in      (word_in),
        .guess_valid  (guess_valid),
        .guess_in     (guess_in),
        .guess_ready  (guess_ready),
        .restart      (restart),
        .letter       (letter),
        .indexCorrect (indexCorrect),
        .mistake      (mistake),
        .numMistake   (numMistake),
        .correct      (correct),
        .word         (word),
        .gameEnd_host (gameEnd_host),
        .game_over    (game_over),
        .win          (win)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference game state: word as left-to-right letters, set of used letters, counters.
    logic [7:0] m_word [5];
    bit         m_used [26];
    int         m_num;
    int         m_cor;

    typedef struct {
        logic [7:0] g;
        bit         acc;
        logic [4:0] mask;
        int         num;
        int         cor;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_letter"}, letter, 0);
        chk({tag, "_idx"}, indexCorrect, 0);
        chk({tag, "_mistake"}, mistake, 0);
        chk({tag, "_num"}, numMistake, 0);
        chk({tag, "_cor"}, correct, 0);
        chk({tag, "_word"}, word, 40'h5F5F5F5F5F);
        chk({tag, "_gameend"}, gameEnd_host, 0);
        chk({tag, "_ready"}, guess_ready, 0);
        chk({tag, "_over"}, game_over, 0);
        chk({tag, "_win"}, win, 0);
    endtask

    task automatic model_new_word(input logic [39:0] w);
        for (int i = 0; i < 5; i++) m_word[i] = w[39 - 8*i -: 8];
        for (int i = 0; i < 26; i++) m_used[i] = 1'b0;
        m_num = 0;
        m_cor = 0;
    endtask

    task automatic model_guess(input logic [7:0] g, output bit acc, output logic [4:0] mask,
                               output int num, output int cor);
        int k;
        int hits;
        k    = int'(g) - 65;
        acc  = (k >= 0) && (k < 26);
        if (acc) acc = !m_used[k];
        mask = '0;
        hits = 0;
        if (acc) begin
            m_used[k] = 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (m_word[i] == g) begin
                    mask[4 - i] = 1'b1;
                    hits++;
                end
            end
            if (hits > 0) m_cor = (m_cor + hits > 5) ? 5 : m_cor + hits;
            else          m_num++;
        end
        num = m_num;
        cor = m_cor;
    endtask

    task automatic load_word(input logic [39:0] w);
        word_valid = 1'b1;
        word_in    = w;
        step();
        word_valid = 1'b0;
        chk("ld_gameend", gameEnd_host, 1);
        chk("ld_mistake", mistake, 0);
        chk("ld_num", numMistake, 0);
        chk("ld_cor", correct, 0);
        chk("ld_word", word, w);
        chk("ld_ready", guess_ready, 0);
        step();
        chk("ld_gameend_drop", gameEnd_host, 0);
        chk("ld_ready_up", guess_ready, 1);
        model_new_word(w);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rs_gameend", gameEnd_host, 1);
        chk("rs_mistake", mistake, 0);
        chk("rs_over", game_over, 0);
        chk("rs_win", win, 0);
        chk("rs_num", numMistake, 0);
        chk("rs_cor", correct, 0);
        chk("rs_ready", guess_ready, 0);
        step();
        chk("rs_gameend_drop", gameEnd_host, 0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!guess_ready && n < 8) begin
            step();
            n++;
        end
        chk("ready_before_guess", guess_ready, 1);
    endtask

    task automatic apply_guess(input logic [7:0] g, input bit acc, input logic [4:0] mask,
                               input int num, input int cor);
        wait_ready();
        guess_valid = 1'b1;
        guess_in    = g;
        step();
        guess_valid = 1'b0;
        guess_in    = 8'($urandom);
        chk("chk_ready", guess_ready, 0);
        chk("chk_mistake", mistake, 0);
        chk("chk_idx", indexCorrect, 0);
        chk("chk_gameend", gameEnd_host, 0);
        step();
        if (!acc) begin
            chk("discard_mistake", mistake, 0);
            chk("discard_idx", indexCorrect, 0);
            chk("discard_num", numMistake, num);
            chk("discard_cor", correct, cor);
            chk("discard_ready", guess_ready, 1);
        end else begin
            chk("apply_letter", letter, g);
            chk("apply_idx", indexCorrect, mask);
            chk("apply_mistake", mistake, mask == 0);
            chk("apply_num", numMistake, num);
            chk("apply_cor", correct, cor);
            chk("apply_ready", guess_ready, 0);
            step();
            if (cor == 5) begin
                chk("win_flag", win, 1);
                chk("win_over", game_over, 1);
                chk("win_mistake", mistake, 0);
                chk("win_idx", indexCorrect, 0);
                chk("win_cor", correct, 5);
                chk("win_ready", guess_ready, 0);
            end else if (num == 6) begin
                chk("lose_mistake", mistake, 1);
                chk("lose_over", game_over, 1);
                chk("lose_win", win, 0);
                chk("lose_num", numMistake, 6);
                chk("lose_ready", guess_ready, 0);
            end else begin
                chk("post_mistake", mistake, 0);
                chk("post_idx", indexCorrect, 0);
                chk("post_ready", guess_ready, 1);
                chk("post_over", game_over, 0);
            end
        end
    endtask

    initial begin
        bit         acc;
        logic [4:0] mask;
        int         num;
        int         cor;
        logic [39:0] w;

        tbl[0] = '{8'h50, 1'b1, 5'b01100, 0, 2};
        tbl[1] = '{8'h5A, 1'b1, 5'b00000, 1, 2};
        tbl[2] = '{8'h50, 1'b0, 5'b00000, 1, 2};
        tbl[3] = '{8'h31, 1'b0, 5'b00000, 1, 2};
        tbl[4] = '{8'h41, 1'b1, 5'b10000, 1, 3};
        tbl[5] = '{8'h4C, 1'b1, 5'b00010, 1, 4};
        tbl[6] = '{8'h45, 1'b1, 5'b00001, 1, 5};

        nRst        = 1'b0;
        word_valid  = 1'b0;
        word_in     = '0;
        guess_valid = 1'b0;
        guess_in    = '0;
        restart     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        nRst = 1'b1;
        step();

        // Directed game on APPLE ending in a win.
        load_word(40'h4150504C45);
        for (int i = 0; i < 7; i++) apply_guess(tbl[i].g, tbl[i].acc, tbl[i].mask, tbl[i].num, tbl[i].cor);
        guess_valid = 1'b1;
        guess_in    = 8'h42;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("win_hold_over", game_over, 1);
            chk("win_hold_win", win, 1);
            chk("win_hold_ready", guess_ready, 0);
            chk("win_hold_cor", correct, 5);
        end
        guess_valid = 1'b0;

        do_restart();
        chk("rs_word_kept", word, 40'h4150504C45);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("idle_restart_ignored", gameEnd_host, 0);
        word_valid = 1'b1;
        word_in    = 40'h4150503145;
        step();
        word_valid = 1'b0;
        chk("bad_word_gameend", gameEnd_host, 0);
        chk("bad_word_kept", word, 40'h4150504C45);
        step();
        chk("bad_word_ready", guess_ready, 0);

        // Six wrong guesses ending in LOSE.
        load_word(40'h4150504C45);
        for (int i = 0; i < 6; i++) begin
            model_guess(8'h51 + 8'(i), acc, mask, num, cor);
            apply_guess(8'h51 + 8'(i), acc, mask, num, cor);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk("lose_hold_mistake", mistake, 1);
            chk("lose_hold_num", numMistake, 6);
            chk("lose_hold_letter", letter, 8'h56);
            chk("lose_hold_over", game_over, 1);
        end

        // Restart racing a guess handshake; word_valid outside IDLE.
        do_restart();
        load_word(40'h48454C4C4F);
        model_guess(8'h4C, acc, mask, num, cor);
        apply_guess(8'h4C, acc, mask, num, cor);
        word_valid = 1'b1;
        word_in    = 40'h4142434445;
        step();
        word_valid = 1'b0;
        chk("busy_word_ignored", word, 40'h48454C4C4F);
        chk("busy_word_gameend", gameEnd_host, 0);
        wait_ready();
        guess_valid = 1'b1;
        guess_in    = 8'h48;
        restart     = 1'b1;
        step();
        guess_valid = 1'b0;
        restart     = 1'b0;
        chk("race_gameend", gameEnd_host, 1);
        chk("race_cor", correct, 0);
        chk("race_num", numMistake, 0);
        chk("race_ready", guess_ready, 0);
        chk("race_word", word, 40'h48454C4C4F);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("race_no_pulse_idx", indexCorrect, 0);
            chk("race_no_pulse_mistake", mistake, 0);
            chk("race_idle_ready", guess_ready, 0);
            chk("race_idle_gameend", gameEnd_host, 0);
        end

        // Asynchronous reset while APPLY is on the outputs.
        load_word(40'h48454C4C4F);
        wait_ready();
        guess_valid = 1'b1;
        guess_in    = 8'h5A;
        step();
        guess_valid = 1'b0;
        step();
        chk("pre_reset_mistake", mistake, 1);
        nRst = 1'b0;
        #2;
        check_reset("mid_apply");
        @(posedge clk);
        #1;
        nRst = 1'b1;
        step();

        // Randomized games on a small alphabet so duplicates and misses are common.
        for (int gm = 0; gm < 20; gm++) begin
            if (game_over) do_restart();
            for (int i = 0; i < 5; i++) w[39 - 8*i -: 8] = 8'h41 + 8'($urandom_range(0, 7));
            load_word(w);
            for (int k = 0; k < 60; k++) begin
                logic [7:0] g;
                if (m_cor == 5 || m_num == 6) break;
                g = 8'h3E + 8'($urandom_range(0, 11));
                repeat ($urandom_range(0, 2)) step();
                model_guess(g, acc, mask, num, cor);
                apply_guess(g, acc, mask, num, cor);
            end
            chk("rand_game_end", game_over, 1);
            chk("rand_win", win, m_cor == 5);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
